data_mem_responder: RTL

- Memory-side responder for the multicycle RV32I core: services the core's single shared instruction/data address port (Adr, WriteData, memwrite, ReadData).
- Contains the unified word-organised RAM, byte/half-word store lane steering, load sign/zero extension, and a small memory-mapped I/O page: an LED register plus free-running micro- and millisecond counters.
- Read latency is one cycle, matching the core's registered instruction and data capture.

---
 rtl/data_mem_responder.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_responder
// Purpose : Unified RAM, LED register and us/ms counters behind the core's
//           shared memory port, with store lane steering and load extension.
// Revision: 1.0  initial release
// ============================================================================
module data_mem_responder #(
    parameter int    MEM_WORDS   = 2048,
    parameter string INIT_FILE   = "",
    parameter int    CLK_FREQ_HZ = 12000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [7:0]  led
);
    localparam int          AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [31:0] RAM_BYTES = 32'(4 * MEM_WORDS);
    localparam int          US_DIV    = (CLK_FREQ_HZ / 1000000 > 1) ? CLK_FREQ_HZ / 1000000 : 1;
    localparam int          PW        = (US_DIV > 1) ? $clog2(US_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(US_DIV - 1);
    localparam logic [29:0] LED_WORD    = 30'h3FFF_FFFF;
    localparam logic [29:0] MILLIS_WORD = 30'h3FFF_FFFE;
    localparam logic [29:0] MICROS_WORD = 30'h3FFF_FFFD;

    logic [31:0] mem [MEM_WORDS];

    logic [31:0]   adr_al;
    logic          sel_led, sel_ms, sel_us, sel_ram;
    logic [AW-1:0] ram_idx;
    logic [3:0]    be;
    logic [31:0]   wlanes;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   rdata_d, rdata_q;
    logic [31:0]   led_d, led_q;
    logic [PW-1:0] presc_q;
    logic [9:0]    ms_sub_q;
    logic [31:0]   micros_q, millis_q;
    logic          tick;

    // Byte accesses keep Adr[1:0]; halves drop bit 0; everything else is a word.
    always_comb begin
        adr_al = Adr;
        if (funct3[1:0] == 2'b01)
            adr_al[0] = 1'b0;
        else if (funct3[1:0] != 2'b00)
            adr_al[1:0] = 2'b00;
    end

    assign sel_led = (adr_al[31:2] == LED_WORD);
    assign sel_ms  = (adr_al[31:2] == MILLIS_WORD);
    assign sel_us  = (adr_al[31:2] == MICROS_WORD);
    assign sel_ram = (adr_al < RAM_BYTES);
    assign ram_idx = adr_al[AW+1:2];

    always_comb begin
        be     = 4'b0000;
        wlanes = WriteData;
        case (funct3)
            3'b000: begin
                be     = 4'b0001 << adr_al[1:0];
                wlanes = {4{WriteData[7:0]}};
            end
            3'b001: begin
                be     = adr_al[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{WriteData[15:0]}};
            end
            3'b010:  be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset && memwrite && sel_ram) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b])
                    mem[ram_idx][8*b +: 8] <= wlanes[8*b +: 8];
            end
        end
    end

    always_comb begin
        led_d = led_q;
        if (memwrite && sel_led) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b])
                    led_d[8*b +: 8] = wlanes[8*b +: 8];
            end
        end
    end

    // Read-first: the word seen here is the pre-edge contents even when written.
    always_comb begin
        rd_word = 32'd0;
        if (sel_led)
            rd_word = led_q;
        else if (sel_ms)
            rd_word = millis_q;
        else if (sel_us)
            rd_word = micros_q;
        else if (sel_ram)
            rd_word = mem[ram_idx];
        rd_byte = rd_word[8*adr_al[1:0] +: 8];
        rd_half = adr_al[1] ? rd_word[31:16] : rd_word[15:0];
        case (funct3)
            3'b000:  rdata_d = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  rdata_d = {24'd0, rd_byte};
            3'b001:  rdata_d = {{16{rd_half[15]}}, rd_half};
            3'b101:  rdata_d = {16'd0, rd_half};
            default: rdata_d = rd_word;
        endcase
    end

    assign tick = (presc_q == PRESC_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q  <= 32'd0;
            led_q    <= 32'd0;
            presc_q  <= '0;
            ms_sub_q <= 10'd0;
            micros_q <= 32'd0;
            millis_q <= 32'd0;
        end else begin
            rdata_q <= rdata_d;
            led_q   <= led_d;
            presc_q <= tick ? '0 : presc_q + PW'(1);
            if (tick) begin
                micros_q <= micros_q + 32'd1;
                if (ms_sub_q == 10'd999) begin
                    ms_sub_q <= 10'd0;
                    millis_q <= millis_q + 32'd1;
                end else begin
                    ms_sub_q <= ms_sub_q + 10'd1;
                end
            end
        end
    end

    assign ReadData = rdata_q;
    assign led      = led_q[7:0];

endmodule
`default_nettype wire
